// File: rtl/ej32_tib_fill_if.sv
// Host-receive, SRAM-write and line-handoff signals of the terminal input buffer filler.
// The echo channel signals exist only when EJ32_TIB_ECHO_EN is defined.
interface ej32_tib_fill_if #(
  parameter int unsigned ASZ = 17
);
  logic           rx_v;
  logic [7:0]     rx_d;
  logic           rx_r;
  logic           mem_req;
  logic           mem_gnt;
  logic           mem_we;
  logic [ASZ-1:0] mem_a;
  logic [7:0]     mem_d;
  logic           line_rdy;
  logic [7:0]     line_len;
  logic           line_ack;
  logic           ovf;
`ifdef EJ32_TIB_ECHO_EN
  logic           echo_v;
  logic [7:0]     echo_d;
  logic           echo_r;

  modport master (
    input  rx_v, rx_d, mem_gnt, line_ack, echo_r,
    output rx_r, mem_req, mem_we, mem_a, mem_d, line_rdy, line_len, ovf, echo_v, echo_d
  );
  modport slave (
    output rx_v, rx_d, mem_gnt, line_ack, echo_r,
    input  rx_r, mem_req, mem_we, mem_a, mem_d, line_rdy, line_len, ovf, echo_v, echo_d
  );
`else
  modport master (
    input  rx_v, rx_d, mem_gnt, line_ack,
    output rx_r, mem_req, mem_we, mem_a, mem_d, line_rdy, line_len, ovf
  );
  modport slave (
    output rx_v, rx_d, mem_gnt, line_ack,
    input  rx_r, mem_req, mem_we, mem_a, mem_d, line_rdy, line_len, ovf
  );
`endif
endinterface

// File: rtl/ej32_tib_fill.sv
// Terminal input buffer filler: queues host bytes and edits them into a line in SRAM.
// Optional byte echo channel is enabled by defining EJ32_TIB_ECHO_EN.
module ej32_tib_fill #(
  parameter int unsigned TIB = 'h1000,
  parameter int unsigned ASZ = 17,
  parameter int unsigned FD  = 4
) (
  input  logic            clk,
  input  logic            rst,
  ej32_tib_fill_if.master bus
);
  localparam int unsigned    PW       = $clog2(FD);
  localparam int unsigned    CW       = PW + 1;
  localparam logic [ASZ-1:0] TIB_A    = ASZ'(TIB);
  localparam logic [CW-1:0]  FULL     = CW'(FD);
  localparam logic [CW-1:0]  ONE      = CW'(1);
  localparam logic [7:0]     CH_CR    = 8'h0D;
  localparam logic [7:0]     CH_LF    = 8'h0A;
  localparam logic [7:0]     CH_BS    = 8'h08;
  localparam logic [7:0]     IDX_LAST = 8'd254;
  localparam logic [7:0]     LEN_MAX  = 8'd255;

  typedef enum logic [1:0] {IDLE, REQ, WR, HOLD} state_e;

  state_e         state_q, state_d;
  logic [7:0]     fifo_q [FD];
  logic [CW-1:0]  wp_q, wp_d, rp_q, rp_d, cnt;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     len_q, len_d;
  logic           ovf_q, ovf_d;
  logic           rdy_q, rdy_d;
  logic           rxr_q, rxr_d;
  logic           push, pop, empty, more, wr_go;
  logic [7:0]     head;
  logic           req_c, we_c;
  logic [ASZ-1:0] a_c;
  logic [7:0]     d_c;

  // Receive FIFO; pointers carry one extra bit so full and empty are distinct.
  assign cnt   = wp_q - rp_q;
  assign empty = (cnt == '0);
  assign push  = bus.rx_v & rxr_q;
  assign head  = fifo_q[rp_q[PW-1:0]];
  assign more  = (cnt != ONE) | push;
  assign wp_d  = wp_q + CW'(push);
  assign rp_d  = rp_q + CW'(pop);
  assign rxr_d = ((wp_d - rp_d) != FULL);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q[PW-1:0]] <= bus.rx_d;
  end

`ifdef EJ32_TIB_ECHO_EN
  logic       echo_v_q, echo_v_d;
  logic [7:0] echo_d_q, echo_d_d;

  // A popped byte must be taken by the echo sink before the next one can be popped.
  assign wr_go = ~(echo_v_q & ~bus.echo_r);

  always_comb begin
    echo_v_d = echo_v_q & ~bus.echo_r;
    echo_d_d = echo_d_q;
    if (pop) begin
      echo_v_d = 1'b1;
      echo_d_d = head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_v_q <= 1'b0;
      echo_d_q <= 8'h00;
    end else begin
      echo_v_q <= echo_v_d;
      echo_d_q <= echo_d_d;
    end
  end

  assign bus.echo_v = echo_v_q;
  assign bus.echo_d = echo_d_q;
`else
  assign wr_go = 1'b1;
`endif

  // Line editor: one FIFO byte per granted WR cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    rdy_d   = rdy_q;
    pop     = 1'b0;
    req_c   = 1'b0;
    we_c    = 1'b0;
    a_c     = '0;
    d_c     = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (!empty && !rdy_q) state_d = REQ;
      end
      REQ: begin
        req_c = 1'b1;
        if (bus.mem_gnt) state_d = WR;
      end
      WR: begin
        req_c = 1'b1;
        if (wr_go) begin
          pop = 1'b1;
          if (head == CH_CR || head == CH_LF) begin
            len_d   = idx_q;
            rdy_d   = 1'b1;
            state_d = HOLD;
          end else if (head == CH_BS) begin
            if (idx_q != 8'd0) idx_d = idx_q - 8'd1;
            state_d = more ? REQ : IDLE;
          end else begin
            we_c  = 1'b1;
            a_c   = TIB_A + ASZ'(idx_q);
            d_c   = head;
            idx_d = idx_q + 8'd1;
            if (idx_q == IDX_LAST) begin
              ovf_d   = 1'b1;
              len_d   = LEN_MAX;
              rdy_d   = 1'b1;
              state_d = HOLD;
            end else begin
              state_d = more ? REQ : IDLE;
            end
          end
        end
      end
      HOLD: begin
        if (bus.line_ack) begin
          idx_d   = 8'd0;
          rdy_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      idx_q   <= 8'd0;
      len_q   <= 8'd0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rxr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
      rxr_q   <= rxr_d;
    end
  end

  // SRAM strobes decode the registered state, so reset removes them at once.
  assign bus.mem_req  = req_c;
  assign bus.mem_we   = we_c;
  assign bus.mem_a    = a_c;
  assign bus.mem_d    = d_c;
  assign bus.rx_r     = rxr_q;
  assign bus.line_rdy = rdy_q;
  assign bus.line_len = len_q;
  assign bus.ovf      = ovf_q;

endmodule
